bus_recorder: RTL and testbench
===============================

BUS_RECORDER -- requirements
Module: bus_recorder

Interface
REQ-001 DATA_WIDTH, 512, monitored bus data width in bits.
REQ-002 SOP_POS_WIDTH, 3, SOP position field width.
REQ-003 EOP_POS_WIDTH, log2(DATA_WIDTH/8), EOP byte-position field width.
REQ-004 ITEMS, 2048, capture memory depth in entries; power of two.
REQ-005 TOTAL_WIDTH = DATA_WIDTH+SOP_POS_WIDTH+EOP_POS_WIDTH+4, entry width (derived, not overridable).
REQ-006 CLK  in  1  single clock; all logic on rising edge.
REQ-007 RESET_N  in  1  asynchronous, active-low reset.
REQ-008 MON_DATA  in  DATA_WIDTH  monitored bus data.
REQ-009 MON_SOP_POS / MON_EOP_POS  in  SOP_POS_WIDTH / EOP_POS_WIDTH  monitored positions.
REQ-010 MON_SOP, MON_EOP, MON_SRC_RDY, MON_DST_RDY  in  1 each  monitored control signals.
REQ-011 START  in  1  pulse; arm capture.
REQ-012 STOP  in  1  pulse; end capture.
REQ-013 RD_ADDR  in  log2(ITEMS)  readout address.
REQ-014 RD_EN  in  1  readout request.
REQ-015 RD_DATA  out  TOTAL_WIDTH  readout entry.
REQ-016 RD_VLD  out  1  RD_DATA valid.
REQ-017 COUNT  out  log2(ITEMS)+1  number of entries stored.
REQ-018 BUSY  out  1  ARMED or CAPTURE state.
REQ-019 DONE  out  1  capture finished (stopped or full).

Function
REQ-020 Entry packing LSB-first: DATA, SOP_POS, EOP_POS, SOP, EOP, SRC_RDY, DST_RDY (DST_RDY at bit TOTAL_WIDTH-1).
REQ-021 Monitor inputs are passive; no output drives the monitored bus.
REQ-022 FSM states IDLE, ARMED, CAPTURE, DONE.
REQ-023 IDLE/DONE + START (no STOP) -> ARMED; COUNT cleared to 0, DONE deasserted, next cycle.
REQ-024 ARMED -> CAPTURE per REQ-038/039; the triggering cycle's sample is stored.
REQ-025 In CAPTURE, every clock cycle's monitored sample is written to address COUNT[log2(ITEMS)-1:0], COUNT increments by 1, regardless of SRC_RDY/DST_RDY values.
REQ-026 When COUNT reaches ITEMS -> DONE; no further writes; COUNT holds ITEMS.
REQ-027 STOP in ARMED or CAPTURE -> DONE next cycle; sample in STOP cycle is not written.
REQ-028 START and STOP asserted in the same cycle: STOP wins; START ignored.
REQ-029 START in ARMED or CAPTURE ignored.
REQ-030 Readout: RD_EN in cycle N -> RD_DATA and RD_VLD=1 in cycle N+1; RD_VLD=0 otherwise.
REQ-031 Readout permitted in any state; reading address >= COUNT returns unspecified data.
REQ-032 Simultaneous write and read of same address returns old contents.
REQ-033 Memory is inferred block RAM, one write port and one read port.

Reset
REQ-034 RESET_N low asynchronously forces IDLE, COUNT=0, BUSY=0, DONE=0, RD_VLD=0.
REQ-035 RD_DATA and memory contents are not reset.
REQ-036 Reset mid-capture discards capture; after release block stays IDLE until START.

Configuration
REQ-037 Macro BUS_RECORDER_TRIGGER_EN selects capture start condition.
REQ-038 Defined: ARMED -> CAPTURE on first cycle with MON_SRC_RDY=1, MON_DST_RDY=1, MON_SOP=1.
REQ-039 Undefined: ARMED lasts exactly one cycle; CAPTURE entered unconditionally.

Verification
REQ-040 Trigger off: START, 10 cycles of counting DATA 0..9, STOP -> COUNT=10, DONE=1; RD_ADDR 0..9 return DATA 0..9 one cycle after RD_EN.
REQ-041 Full: START, no STOP for 2100 cycles -> COUNT=2048, DONE=1, entry 2047 equals sample 2047, no overwrite of entry 0.
REQ-042 Trigger on: START, 5 idle cycles, then SRC_RDY=DST_RDY=SOP=1 with SOP_POS=5 -> entry 0 holds that sample, SOP_POS field=5, bit TOTAL_WIDTH-1=1.
REQ-043 START and STOP same cycle from IDLE -> state unchanged, COUNT=0, BUSY=0.
REQ-044 RESET_N low at COUNT=37 during CAPTURE -> immediately COUNT=0, BUSY=0, DONE=0; stays IDLE after release.
REQ-045 Restart after DONE: second START -> COUNT restarts at 0, DONE=0, new samples overwrite entries from 0.

Source files
------------

// File: rtl/bus_recorder_if.sv
// Monitored streaming-bus signals observed (never driven) by bus_recorder.
interface bus_recorder_if #(
  parameter int DATA_WIDTH    = 512,
  parameter int SOP_POS_WIDTH = 3,
  parameter int EOP_POS_WIDTH = $clog2(DATA_WIDTH/8)
);
  logic [DATA_WIDTH-1:0]    data;
  logic [SOP_POS_WIDTH-1:0] sop_pos;
  logic [EOP_POS_WIDTH-1:0] eop_pos;
  logic                     sop;
  logic                     eop;
  logic                     src_rdy;
  logic                     dst_rdy;

  modport master (output data, sop_pos, eop_pos, sop, eop, src_rdy, dst_rdy);
  modport slave  (input  data, sop_pos, eop_pos, sop, eop, src_rdy, dst_rdy);
endinterface

// File: rtl/bus_recorder.sv
// Passive bus recorder: captures one monitored sample per cycle into block RAM after START.
// Define BUS_RECORDER_TRIGGER_EN to wait for SRC_RDY & DST_RDY & SOP before capturing.
module bus_recorder #(
  parameter int  DATA_WIDTH    = 512,
  parameter int  SOP_POS_WIDTH = 3,
  parameter int  EOP_POS_WIDTH = $clog2(DATA_WIDTH/8),
  parameter int  ITEMS         = 2048,
  localparam int ADDR_WIDTH    = $clog2(ITEMS),
  localparam int TOTAL_WIDTH   = DATA_WIDTH + SOP_POS_WIDTH + EOP_POS_WIDTH + 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  bus_recorder_if.slave          mon,
  input  logic                   start,
  input  logic                   stop,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  input  logic                   rd_en,
  output logic [TOTAL_WIDTH-1:0] rd_data,
  output logic                   rd_vld,
  output logic [ADDR_WIDTH:0]    count,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_CAPTURE, ST_DONE} state_t;

  localparam logic [ADDR_WIDTH:0] COUNT_FULL = (ADDR_WIDTH+1)'(ITEMS);
  localparam logic [ADDR_WIDTH:0] COUNT_ONE  = (ADDR_WIDTH+1)'(1);

  state_t                 state, state_nxt;
  logic [ADDR_WIDTH:0]    count_nxt;
  logic                   wr_en;
  logic                   trigger;
  logic [TOTAL_WIDTH-1:0] sample;
  logic [TOTAL_WIDTH-1:0] mem [ITEMS];

  // Entry layout, LSB first: data, sop_pos, eop_pos, sop, eop, src_rdy, dst_rdy.
  assign sample = {mon.dst_rdy, mon.src_rdy, mon.eop, mon.sop,
                   mon.eop_pos, mon.sop_pos, mon.data};

`ifdef BUS_RECORDER_TRIGGER_EN
  assign trigger = mon.src_rdy & mon.dst_rdy & mon.sop;
`else
  assign trigger = 1'b1;
`endif

  // NOTE: every output of this block gets a default before the case, so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    wr_en     = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start && !stop) begin
          state_nxt = ST_ARMED;
          count_nxt = '0;
        end
      end
      ST_ARMED: begin
        if (stop) begin
          state_nxt = ST_DONE;
        end else if (trigger) begin
          wr_en     = 1'b1;
          count_nxt = count + COUNT_ONE;
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (stop) begin
          state_nxt = ST_DONE;
        end else begin
          wr_en     = 1'b1;
          count_nxt = count + COUNT_ONE;
          if (count_nxt == COUNT_FULL) state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its inputs, independent of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      count  <= '0;
      rd_vld <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      rd_vld <= rd_en;
    end
  end

  assign busy = (state == ST_ARMED) || (state == ST_CAPTURE);
  assign done = (state == ST_DONE);

  // NOTE: the capture array and read register carry no reset; a reset would
  // prevent mapping onto block RAM. Same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[count[ADDR_WIDTH-1:0]] <= sample;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_bus_recorder.sv
// Self-checking bench for bus_recorder: directed scenarios plus randomized traffic,
// all compared every cycle against a queue/array-level model of the recorder.
`timescale 1ns/1ps
module tb_bus_recorder;
  localparam int DW    = 512;
  localparam int SPW   = 3;
  localparam int EPW   = $clog2(DW/8);
  localparam int ITEMS = 2048;
  localparam int AW    = $clog2(ITEMS);
  localparam int TW    = DW + SPW + EPW + 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [TW-1:0] rd_data;
  logic          rd_vld;
  logic [AW:0]   count;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  bus_recorder_if #(.DATA_WIDTH(DW), .SOP_POS_WIDTH(SPW), .EOP_POS_WIDTH(EPW)) mon ();

  bus_recorder #(
    .DATA_WIDTH(DW), .SOP_POS_WIDTH(SPW), .EOP_POS_WIDTH(EPW), .ITEMS(ITEMS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .mon(mon),
    .start(start), .stop(stop), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data), .rd_vld(rd_vld), .count(count), .busy(busy), .done(done)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {P_IDLE, P_ARMED, P_CAPTURE, P_DONE} phase_t;
  phase_t        m_phase = P_IDLE;
  int            m_count = 0;
  logic [TW-1:0] m_mem [ITEMS];
  bit            m_known [ITEMS];
  bit            m_vld = 1'b0;
  bit            m_rd_known = 1'b0;
  logic [TW-1:0] m_rd_data = '0;

  always @(posedge clk) begin : model_step
    logic [TW-1:0] s;
    bit            trig;
    if (reset_n) begin
      s = {mon.dst_rdy, mon.src_rdy, mon.eop, mon.sop, mon.eop_pos, mon.sop_pos, mon.data};
`ifdef BUS_RECORDER_TRIGGER_EN
      trig = mon.src_rdy && mon.dst_rdy && mon.sop;
`else
      trig = 1'b1;
`endif
      // readout sees the array before this cycle's write
      m_vld = rd_en;
      if (rd_en) begin
        m_rd_data  = m_mem[rd_addr];
        m_rd_known = m_known[rd_addr];
      end
      case (m_phase)
        P_IDLE, P_DONE: begin
          if (start && !stop) begin
            m_phase = P_ARMED;
            m_count = 0;
          end
        end
        default: begin
          if (stop) begin
            m_phase = P_DONE;
          end else if (m_phase == P_CAPTURE || trig) begin
            m_mem[m_count]   = s;
            m_known[m_count] = 1'b1;
            m_count++;
            m_phase = (m_count == ITEMS) ? P_DONE : P_CAPTURE;
          end
        end
      endcase
    end
  end

  always @(negedge reset_n) begin
    m_phase = P_IDLE;
    m_count = 0;
    m_vld   = 1'b0;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("count", TW'(count), TW'(m_count));
      check("busy", TW'(busy), TW'(m_phase == P_ARMED || m_phase == P_CAPTURE));
      check("done", TW'(done), TW'(m_phase == P_DONE));
      check("rd_vld", TW'(rd_vld), TW'(m_vld));
      if (m_vld && m_rd_known) check("rd_data", rd_data, m_rd_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // ctl = {dst_rdy, src_rdy, eop, sop}
  task automatic set_bus(input logic [DW-1:0] d, input logic [SPW-1:0] sp,
                         input logic [EPW-1:0] ep, input logic [3:0] ctl);
    mon.data    = d;
    mon.sop_pos = sp;
    mon.eop_pos = ep;
    {mon.dst_rdy, mon.src_rdy, mon.eop, mon.sop} = ctl;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic read_entry(input int addr, output logic [TW-1:0] v);
    rd_en   = 1'b1;
    rd_addr = AW'(addr);
    tick();
    v = rd_data;
    check("rd_vld_after_en", TW'(rd_vld), TW'(1));
    rd_en = 1'b0;
  endtask

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [TW-1:0] v;
    logic [TW-1:0] trig_sample;
    set_bus('0, '0, '0, 4'b0000);

    repeat (3) @(posedge clk);
    #1;
    check("reset_count", TW'(count), TW'(0));
    check("reset_busy", TW'(busy), TW'(0));
    check("reset_done", TW'(done), TW'(0));
    check("reset_rd_vld", TW'(rd_vld), TW'(0));
    reset_n = 1'b1;
    chk_en  = 1'b1;
    tick();

    // START and STOP together from IDLE: nothing happens
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    tick();
    check("startstop_busy", TW'(busy), TW'(0));
    check("startstop_count", TW'(count), TW'(0));
    check("startstop_done", TW'(done), TW'(0));

    // ten counting samples then STOP
    set_bus('0, '0, '0, 4'b1111);
    pulse_start();
    check("armed_busy", TW'(busy), TW'(1));
    for (int k = 0; k < 10; k++) begin
      mon.data = DW'(k);
      tick();
    end
    pulse_stop();
    check("cnt10_count", TW'(count), TW'(10));
    check("cnt10_done", TW'(done), TW'(1));
    for (int k = 0; k < 10; k++) begin
      read_entry(k, v);
      check("cnt10_data", TW'(v[DW-1:0]), TW'(k));
    end

    // restart after DONE overwrites from entry 0
    pulse_start();
    check("restart_count", TW'(count), TW'(0));
    check("restart_done", TW'(done), TW'(0));
    for (int k = 0; k < 3; k++) begin
      mon.data = DW'(100 + k);
      tick();
    end
    pulse_stop();
    check("restart_count3", TW'(count), TW'(3));
    for (int k = 0; k < 3; k++) begin
      read_entry(k, v);
      check("restart_data", TW'(v[DW-1:0]), TW'(100 + k));
    end
    read_entry(5, v);
    check("restart_old_entry5", TW'(v[DW-1:0]), TW'(5));

`ifdef BUS_RECORDER_TRIGGER_EN
    // trigger waits through idle cycles, then stores the triggering sample
    set_bus(rand_data(), 3'd5, '0, 4'b0000);
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      set_bus(rand_data(), SPW'($urandom()), EPW'($urandom()), 4'b0010);
      tick();
    end
    check("trig_wait_count", TW'(count), TW'(0));
    check("trig_wait_busy", TW'(busy), TW'(1));
    set_bus(rand_data(), 3'd5, EPW'($urandom()), 4'b1101);
    trig_sample = {mon.dst_rdy, mon.src_rdy, mon.eop, mon.sop, mon.eop_pos, mon.sop_pos, mon.data};
    tick();
    set_bus(rand_data(), '0, '0, 4'b0000);
    tick();
    pulse_stop();
    check("trig_count", TW'(count), TW'(2));
    read_entry(0, v);
    check("trig_sop_pos", TW'(v[DW +: SPW]), TW'(5));
    check("trig_msb", TW'(v[TW-1]), TW'(1));
    check("trig_entry", v, trig_sample);
`else
    trig_sample = '0;
`endif

    // reset in the middle of a capture
    set_bus('0, '0, '0, 4'b1111);
    pulse_start();
    for (int k = 0; k < 37; k++) begin
      mon.data = rand_data();
      tick();
    end
    check("midreset_pre_count", TW'(count), TW'(37));
    reset_n = 1'b0;
    #1;
    check("midreset_count", TW'(count), TW'(0));
    check("midreset_busy", TW'(busy), TW'(0));
    check("midreset_done", TW'(done), TW'(0));
    check("midreset_rd_vld", TW'(rd_vld), TW'(0));
    #2;
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mon.data = rand_data();
      tick();
    end
    check("postreset_busy", TW'(busy), TW'(0));
    check("postreset_count", TW'(count), TW'(0));

    // randomized traffic, START/STOP pulses and readout
    for (int n = 0; n < 1500; n++) begin
      set_bus(rand_data(), SPW'($urandom()), EPW'($urandom()), 4'($urandom()));
      start = ($urandom_range(0, 23) == 0);
      stop  = ($urandom_range(0, 47) == 0);
      rd_en = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) == 0) rd_addr = AW'(m_count);
      else                           rd_addr = AW'($urandom());
      tick();
    end
    start = 1'b0;
    rd_en = 1'b0;
    pulse_stop();
    tick();

    // fill the whole memory without STOP
    set_bus('0, '0, '0, 4'b1111);
    pulse_start();
    for (int k = 0; k < 2100; k++) begin
      mon.data = DW'(k);
      tick();
    end
    check("full_count", TW'(count), TW'(ITEMS));
    check("full_done", TW'(done), TW'(1));
    check("full_busy", TW'(busy), TW'(0));
    read_entry(ITEMS - 1, v);
    check("full_last_entry", TW'(v[DW-1:0]), TW'(ITEMS - 1));
    read_entry(0, v);
    check("full_entry0", TW'(v[DW-1:0]), TW'(0));
    read_entry(1024, v);
    check("full_entry1024", TW'(v[DW-1:0]), TW'(1024));
    tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
